fetch_decode_queue: RTL and testbench
=====================================

// Module: fetch_decode_queue
// PURPOSE
//   Instruction queue between the fetch unit and the decode stage; it drives the decode stage's
//   instruction, pc, compflg and instr_valid inputs.
//   Buffers up to DEPTH fetched instructions so fetch keeps running while decode is stalled.
//   Drops all buffered instructions on a pipeline flush (taken branch or jump).
// PARAMETERS
//   DEPTH   4    number of queue entries; power of two, >= 2
//   XLEN    32   width of pc
// PORTS
//   clk                input   1         clock; all state updates on rising edge
//   rst_n              input   1         asynchronous active-low reset
//   fetch_valid        input   1         fetch presents a packet
//   fetch_ready        output  1         queue accepts the packet this cycle
//   fetch_instruction  input   32        instruction word (instruction_type)
//   fetch_pc           input   XLEN      pc of the fetched instruction
//   fetch_compflg      input   1         instruction was expanded from a 16-bit compressed encoding
//   decode_stall       input   1         decode holds its current instruction; no pop
//   flush              input   1         discard all entries
//   instruction        output  32        head instruction to decode (instruction_type)
//   pc                 output  XLEN      head pc
//   compflg            output  1         head compressed flag
//   instr_valid        output  1         head entry is valid
//   count              output  $clog2(DEPTH+1)   occupancy
// BEHAVIOUR
//   - Clock and reset: single clock clk; reset is asynchronous and active-low (rst_n).
//   - Reset: storage, pointers and count are cleared; count=0, instr_valid=0, fetch_ready=1.
//     On reset, instruction=NOP_INSTR (32'h0000_0013), pc=0, compflg=0.
//   - Push: fetch_valid && fetch_ready && !flush writes the packet at wr_ptr. wr_ptr increments modulo DEPTH.
//   - Pop: instr_valid && !decode_stall && !flush advances rd_ptr modulo DEPTH.
//   - fetch_ready = (count != DEPTH). It depends on registered state only; there is no combinational path from decode_stall.
//   - Outputs: combinational read of the entry at rd_ptr.
//     instr_valid = (count != 0). When count==0: instruction=NOP_INSTR, pc=0, compflg=0.
//   - Latency: a packet pushed in cycle N is visible at the outputs in cycle N+1 (one-cycle first-word latency).
//     No bypass from fetch to decode.
//   - Simultaneous push and pop: count is unchanged and both pointers advance. This is legal at any occupancy where fetch_ready=1.
//   - Full: a push is not accepted even if a pop occurs in the same cycle. Fetch must hold its packet (valid/ready rule).
//   - Empty: no pop occurs; decode_stall is don't-care.
//   - Flush has priority over push and pop.
//     Next cycle: count=0, rd_ptr=wr_ptr=0, instr_valid=0. A packet presented with flush is dropped, not stored.
//   - The decode_stall and flush inputs are assumed glitch-free and synchronous to clk.
//   - Reset mid-operation: asynchronous clear as above. No partial entries survive reset.
//   - Fetch protocol: once asserted, fetch_valid and its payload must stay stable until accepted, except across a flush.
//     The queue does not check this rule; the bench asserts it.
//   - Width rule: count width is $clog2(DEPTH+1). Pointer width is $clog2(DEPTH).
//     Wrap-around is natural overflow because DEPTH is a power of two.
// STRUCTURE
//   - Package common gains:
//     - NOP_INSTR constant, used as the idle value for instruction;
//     - fetch_packet_t packed struct {instruction_type instr; logic [31:0] pc; logic compflg};
//     - FETCH_Q_DEPTH default constant.
//   - Storage is a fetch_packet_t array plus pointers and a counter in this module. No sub-module is needed.
//   - A generic sync_fifo is not used, because the flush semantics and NOP idle output are specific to this block.
// TESTING
//   1. Reset: assert rst_n=0 mid-cycle -> instr_valid=0, count=0, fetch_ready=1, instruction=32'h13 immediately.
//   2. Single push: push {instr=32'h00500093, pc=32'h100, compflg=0} with no stall.
//      -> next cycle instr_valid=1, pc=32'h100. Popped the following cycle; count returns to 0.
//   3. Fill under stall: decode_stall=1, push pc 0x0,0x4,0x8,0xC.
//      -> count=4, fetch_ready=0, and a fifth packet (pc 0x10) is held.
//      Release the stall -> decode sees 0x0,0x4,0x8,0xC,0x10 in order, one per cycle.
//   4. Simultaneous push and pop at count=2 for 10 cycles -> count stays 2 and the pc stream is in order.
//      Covers pointer wrap-around past index 3.
//   5. Flush while full with fetch_valid=1 (pc 0x20) -> next cycle count=0, instr_valid=0.
//      The pc 0x20 packet is not stored. The next push after flush appears first.
//   6. Compressed flag: push {instr=32'h00000513, pc=32'h202, compflg=1} -> outputs compflg=1, pc=32'h202.

Source files
------------

// File: rtl/fetch_decode_queue_pkg.sv
// Shared fetch/decode types: instruction word, queued fetch packet and the idle NOP encoding.
package fetch_decode_queue_pkg;

   typedef logic [31:0] instruction_type;

   // addi x0, x0, 0
   localparam instruction_type NOP_INSTR = 32'h0000_0013;

   localparam int FETCH_Q_DEPTH = 4;

   typedef struct packed {
      instruction_type instr;
      logic [31:0]     pc;
      logic            compflg;
   } fetch_packet_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue of DEPTH entries; flush drops everything. Push-to-head latency 1 cycle, no bypass.
// Backpressure: fetch_ready = not full, from registered state only; decode_stall holds the head entry.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH = FETCH_Q_DEPTH,
   parameter int XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       fetch_valid,
   output logic                       fetch_ready,
   input  logic [31:0]                fetch_instruction,
   input  logic [XLEN-1:0]            fetch_pc,
   input  logic                       fetch_compflg,
   input  logic                       decode_stall,
   input  logic                       flush,
   output logic [31:0]                instruction,
   output logic [XLEN-1:0]            pc,
   output logic                       compflg,
   output logic                       instr_valid,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_packet_t mem [DEPTH];
   fetch_packet_t head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   assign fetch_ready = (cnt != CW'(DEPTH));
   assign instr_valid = (cnt != '0);
   assign count       = cnt;

   // Full blocks a push even when decode pops in the same cycle.
   assign push = fetch_valid && fetch_ready && !flush;
   assign pop  = instr_valid && !decode_stall && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= '{instr: fetch_instruction, pc: 32'(fetch_pc), compflg: fetch_compflg};
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            cnt <= cnt + CW'(1);
         end else if (pop && !push) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      instruction = NOP_INSTR;
      pc          = '0;
      compflg     = 1'b0;
      if (instr_valid) begin
         instruction = head.instr;
         pc          = XLEN'(head.pc);
         compflg     = head.compflg;
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench: driver keeps an ordered list of packets decode should see; monitor checks head/count each cycle.
module tb_fetch_decode_queue;
   import fetch_decode_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            fetch_valid = 1'b0;
   logic            fetch_ready;
   logic [31:0]     fetch_instruction = '0;
   logic [XLEN-1:0] fetch_pc = '0;
   logic            fetch_compflg = 1'b0;
   logic            decode_stall = 1'b0;
   logic            flush = 1'b0;
   logic [31:0]     instruction;
   logic [XLEN-1:0] pc;
   logic            compflg;
   logic            instr_valid;
   logic [CW-1:0]   count;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   fetch_packet_t exp_q[$];
   bit            pend_v = 1'b0;
   fetch_packet_t pend = '0;

   always #5 clk = ~clk;

   fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
      .fetch_instruction(fetch_instruction), .fetch_pc(fetch_pc), .fetch_compflg(fetch_compflg),
      .decode_stall(decode_stall), .flush(flush),
      .instruction(instruction), .pc(pc), .compflg(compflg),
      .instr_valid(instr_valid), .count(count)
   );

   // Fetch must hold a refused packet steady until accepted (flush excepted).
   assert property (@(posedge clk) disable iff (!rst_n)
      (fetch_valid && !fetch_ready && !flush) |=>
         (fetch_valid && $stable(fetch_pc) && $stable(fetch_instruction) && $stable(fetch_compflg)));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic fetch_packet_t mk(input logic [31:0] i, input logic [31:0] p, input logic c);
      mk = '{instr: i, pc: p, compflg: c};
   endfunction

   // Monitor: the DUT head must match the oldest packet the model says is still queued.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("count",       64'(count),       64'(exp_q.size()));
         chk("fetch_ready", 64'(fetch_ready), 64'(exp_q.size() != DEPTH));
         chk("instr_valid", 64'(instr_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            chk("head_instr",   64'(instruction), 64'(exp_q[0].instr));
            chk("head_pc",      64'(pc),          64'(exp_q[0].pc));
            chk("head_compflg", 64'(compflg),     64'(exp_q[0].compflg));
         end else begin
            chk("idle_instr",   64'(instruction), 64'(NOP_INSTR));
            chk("idle_pc",      64'(pc),          64'(0));
            chk("idle_compflg", 64'(compflg),     64'(0));
         end
      end
   end

   // One cycle of stimulus, driven just after a negedge; the model reflects the state after the next posedge.
   task automatic step(input bit new_v, input fetch_packet_t np, input bit stall, input bit fl);
      bit acc;
      if (!pend_v && new_v) begin
         pend   = np;
         pend_v = 1'b1;
      end
      fetch_valid       = pend_v;
      fetch_instruction = pend.instr;
      fetch_pc          = pend.pc;
      fetch_compflg     = pend.compflg;
      decode_stall      = stall;
      flush             = fl;
      if (fl) begin
         exp_q.delete();
         pend_v = 1'b0;
      end else begin
         acc = pend_v && (exp_q.size() < DEPTH);
         if (exp_q.size() != 0 && !stall) void'(exp_q.pop_front());
         if (acc) begin
            exp_q.push_back(pend);
            pend_v = 1'b0;
         end
      end
      @(negedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"},       64'(count),       64'(0));
      chk({tag, "_instr_valid"}, 64'(instr_valid), 64'(0));
      chk({tag, "_fetch_ready"}, 64'(fetch_ready), 64'(1));
      chk({tag, "_instr"},       64'(instruction), 64'(32'h13));
      chk({tag, "_pc"},          64'(pc),          64'(0));
      chk({tag, "_compflg"},     64'(compflg),     64'(0));
   endtask

   initial begin
      fetch_packet_t z;
      z = '0;

      // Reset asserted mid-cycle, outputs checked before any clock edge.
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("reset");
      @(negedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // Single push, then popped.
      step(1, mk(32'h0050_0093, 32'h100, 1'b0), 0, 0);
      step(0, z, 0, 0);
      step(0, z, 0, 0);

      // Fill under stall, fifth packet held, then drain in order.
      for (int i = 0; i < 4; i++) step(1, mk($urandom, 32'(i * 4), 1'b0), 1, 0);
      step(1, mk($urandom, 32'h10, 1'b0), 1, 0);
      step(1, z, 1, 0);
      for (int i = 0; i < 7; i++) step(0, z, 0, 0);

      // Steady push+pop at occupancy 2, wrapping the pointers.
      step(1, mk($urandom, 32'h40, 1'b0), 1, 0);
      step(1, mk($urandom, 32'h44, 1'b0), 1, 0);
      for (int i = 0; i < 10; i++) step(1, mk($urandom, 32'(32'h48 + i * 4), 1'b0), 0, 0);
      for (int i = 0; i < 3; i++) step(0, z, 0, 0);

      // Flush while full with a packet presented: it must be dropped.
      for (int i = 0; i < 4; i++) step(1, mk($urandom, 32'(32'h80 + i * 4), 1'b0), 1, 0);
      step(1, mk(32'h1111_1111, 32'h20, 1'b0), 1, 1);
      step(1, mk(32'h2222_2222, 32'h24, 1'b0), 1, 0);
      step(0, z, 0, 0);
      step(0, z, 0, 0);

      // Compressed flag passes through.
      step(1, mk(32'h0000_0513, 32'h202, 1'b1), 0, 0);
      step(0, z, 0, 0);
      step(0, z, 0, 0);

      // Randomized traffic with stalls and occasional flushes.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 99) < 70, mk($urandom, $urandom, 1'($urandom_range(0, 1))),
              $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 5);
      end

      // Asynchronous reset mid-operation with a partially full queue.
      for (int i = 0; i < 3; i++) step(1, mk($urandom, $urandom, 1'b1), 1, 0);
      #2 rst_n = 1'b0;
      #1 chk_reset_outputs("midreset");
      exp_q.delete();
      pend_v = 1'b0;
      fetch_valid = 1'b0;
      decode_stall = 1'b0;
      flush = 1'b0;
      @(negedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < 300; i++) begin
         step($urandom_range(0, 99) < 80, mk($urandom, $urandom, 1'($urandom_range(0, 1))),
              $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 3);
      end
      for (int i = 0; i < DEPTH + 3; i++) step(0, z, 0, 0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
